// File: rtl/p_div.sv
// Packed restoring divider, 32/16/8/4/2-bit lanes; signed lanes with P_DIV_SIGNED_EN.
// Latency: ready pulses in cycle w+1 after acceptance (w = lane width).
// Backpressure: valid is held until ready; dropping valid aborts the operation.
module p_div (
  input  logic        clock,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic        div_q,
  input  logic        div_r,
  input  logic [4:0]  pw,
  input  logic [31:0] crs1,
  input  logic [31:0] crs2,
`ifdef P_DIV_SIGNED_EN
  input  logic        div_s,
`endif
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d, last;
  logic [4:0]  pw_q, pw_d;
  logic [31:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
  logic        selq_q, selq_d, selr_q, selr_d, bad_q, bad_d;
  logic        clr;
  logic [31:0] dvd_step, rem_step, ld_dvd, ld_dvs, quot, remo;

  // One restoring step for every lane width; the active one is picked by pw_q.
  for (genvar k = 0; k < 5; k++) begin : g_w
    localparam int W = 32 >> k;
    logic [31:0] rem_n, dvd_n;
    always_comb begin
      logic [W:0] rp;
      rem_n = '0;
      dvd_n = '0;
      rp    = '0;
      for (int l = 0; l < 32 / W; l++) begin
        rp = {rem_q[l*W +: W], dvd_q[l*W+W-1]};
        if (rp >= {1'b0, dvs_q[l*W +: W]}) begin
          rem_n[l*W +: W] = rp[W-1:0] - dvs_q[l*W +: W];
          dvd_n[l*W +: W] = {dvd_q[l*W +: W-1], 1'b1};
        end else begin
          rem_n[l*W +: W] = rp[W-1:0];
          dvd_n[l*W +: W] = {dvd_q[l*W +: W-1], 1'b0};
        end
      end
    end
  end

  always_comb begin
    rem_step = rem_q;
    dvd_step = dvd_q;
    last     = '0;
    case (pw_q)
      5'b00001: begin rem_step = g_w[0].rem_n; dvd_step = g_w[0].dvd_n; last = 5'd31; end
      5'b00010: begin rem_step = g_w[1].rem_n; dvd_step = g_w[1].dvd_n; last = 5'd15; end
      5'b00100: begin rem_step = g_w[2].rem_n; dvd_step = g_w[2].dvd_n; last = 5'd7;  end
      5'b01000: begin rem_step = g_w[3].rem_n; dvd_step = g_w[3].dvd_n; last = 5'd3;  end
      5'b10000: begin rem_step = g_w[4].rem_n; dvd_step = g_w[4].dvd_n; last = 5'd1;  end
      default: ;
    endcase
  end

`ifdef P_DIV_SIGNED_EN
  logic [31:0] s1m_q, s1m_d, s2m_q, s2m_d, ld_s1m, ld_s2m;

  // Bit set at the lowest bit of every lane.
  function automatic logic [31:0] lane_lsb(input logic [4:0] p);
    case (p)
      5'b00001: return 32'h0000_0001;
      5'b00010: return 32'h0001_0001;
      5'b00100: return 32'h0101_0101;
      5'b01000: return 32'h1111_1111;
      5'b10000: return 32'h5555_5555;
      default:  return 32'h0;
    endcase
  endfunction

  // Copy the bit found at each lane msb across the whole lane.
  function automatic logic [31:0] spread(input logic [31:0] x, input logic [31:0] msb);
    logic [31:0] y;
    logic        cur;
    y = '0;
    cur = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (msb[i]) cur = x[i];
      y[i] = cur;
    end
    return y;
  endfunction

  function automatic logic [31:0] or_scan(input logic [31:0] x, input logic [31:0] ls);
    logic [31:0] y;
    logic        acc;
    y = '0;
    acc = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (ls[i]) acc = 1'b0;
      acc  = acc | x[i];
      y[i] = acc;
    end
    return y;
  endfunction

  // Two's-complement negation of the lanes selected by m; carries restart at lane lsbs.
  function automatic logic [31:0] lane_neg(input logic [31:0] x, input logic [31:0] m,
                                           input logic [31:0] ls);
    logic [31:0] y;
    logic        c;
    y = '0;
    c = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (ls[i]) c = 1'b1;
      y[i] = m[i] ? (~x[i] ^ c) : x[i];
      c    = ~x[i] & c;
    end
    return y;
  endfunction

  always_comb begin
    logic [31:0] ls_i, ls_o, nz;
    ls_i   = lane_lsb(pw);
    ld_s1m = div_s ? spread(crs1, {ls_i[0], ls_i[31:1]}) : '0;
    ld_s2m = div_s ? spread(crs2, {ls_i[0], ls_i[31:1]}) : '0;
    ld_dvd = lane_neg(crs1, ld_s1m, ls_i);
    ld_dvs = lane_neg(crs2, ld_s2m, ls_i);
    ls_o   = lane_lsb(pw_q);
    // Divide-by-zero lanes keep the all-ones quotient (-1) regardless of dividend sign.
    nz     = spread(or_scan(dvs_q, ls_o), {ls_o[0], ls_o[31:1]});
    quot   = lane_neg(dvd_q, (s1m_q ^ s2m_q) & nz, ls_o);
    remo   = lane_neg(rem_q, s1m_q, ls_o);
  end
`else
  assign ld_dvd = crs1;
  assign ld_dvs = crs2;
  assign quot   = dvd_q;
  assign remo   = rem_q;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pw_d    = pw_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    selq_d  = selq_q;
    selr_d  = selr_q;
    bad_d   = bad_q;
    clr     = 1'b0;
`ifdef P_DIV_SIGNED_EN
    s1m_d   = s1m_q;
    s2m_d   = s2m_q;
`endif
    case (state_q)
      IDLE: if (valid) begin
        pw_d    = pw;
        dvd_d   = ld_dvd;
        dvs_d   = ld_dvs;
        rem_d   = '0;
        count_d = '0;
        selq_d  = div_q;
        selr_d  = div_r & ~div_q;
        bad_d   = !$onehot(pw);
        state_d = $onehot(pw) ? RUN : DONE;
`ifdef P_DIV_SIGNED_EN
        s1m_d   = ld_s1m;
        s2m_d   = ld_s2m;
`endif
      end
      RUN: if (!valid) begin
        clr = 1'b1;
      end else begin
        dvd_d   = dvd_step;
        rem_d   = rem_step;
        count_d = count_q + 5'd1;
        if (count_q == last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        clr     = !valid;
      end
      default: clr = 1'b1;
    endcase
    if (clr) begin
      state_d = IDLE;
      count_d = '0;
      pw_d    = '0;
      dvd_d   = '0;
      dvs_d   = '0;
      rem_d   = '0;
      selq_d  = 1'b0;
      selr_d  = 1'b0;
      bad_d   = 1'b0;
`ifdef P_DIV_SIGNED_EN
      s1m_d   = '0;
      s2m_d   = '0;
`endif
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      count_q <= '0;
      pw_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      selq_q  <= 1'b0;
      selr_q  <= 1'b0;
      bad_q   <= 1'b0;
`ifdef P_DIV_SIGNED_EN
      s1m_q   <= '0;
      s2m_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pw_q    <= pw_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      selq_q  <= selq_d;
      selr_q  <= selr_d;
      bad_q   <= bad_d;
`ifdef P_DIV_SIGNED_EN
      s1m_q   <= s1m_d;
      s2m_q   <= s2m_d;
`endif
    end
  end

  assign ready = (state_q == DONE) && valid;

  always_comb begin
    result = '0;
    if (ready && !bad_q) begin
      if (selq_q)      result = quot;
      else if (selr_q) result = remo;
    end
  end

endmodule

// File: tb/tb_p_div.sv
// Self-checking bench for p_div: per-lane arithmetic model, directed pins and random operations.
module tb_p_div;

  logic        clock = 1'b0;
  logic        resetn, valid, ready, div_q, div_r, div_s;
  logic [4:0]  pw;
  logic [31:0] crs1, crs2, result;

  int          cyc = 0, checks = 0, errors = 0, start_cyc = 0, exp_lat = 0;
  logic        pending = 1'b0;
  logic [31:0] exp_res = '0;

  p_div dut (
    .clock  (clock),
    .resetn (resetn),
    .valid  (valid),
    .ready  (ready),
    .div_q  (div_q),
    .div_r  (div_r),
    .pw     (pw),
    .crs1   (crs1),
    .crs2   (crs2),
`ifdef P_DIV_SIGNED_EN
    .div_s  (div_s),
`endif
    .result (result)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic int lane_w(input logic [4:0] p);
    case (p)
      5'b00001: return 32;
      5'b00010: return 16;
      5'b00100: return 8;
      5'b01000: return 4;
      5'b10000: return 2;
      default:  return 0;
    endcase
  endfunction

  // Lane-by-lane arithmetic reference.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] p, input logic dq, input logic dr,
                                        input logic sg);
    int w;
    longint mask, half, full, sa, sb, q, r, v, res;
    w = lane_w(p);
    if (w == 0) return 32'h0;
    full = longint'(1) << w;
    half = longint'(1) << (w - 1);
    mask = full - 1;
    res  = 0;
    for (int l = 0; l < 32 / w; l++) begin
      sa = (longint'(a) >> (l * w)) & mask;
      sb = (longint'(b) >> (l * w)) & mask;
      if (sg && sa >= half) sa = sa - full;
      if (sg && sb >= half) sb = sb - full;
      if (sb == 0) begin
        q = sg ? -1 : mask;
        r = sa;
      end else if (sg && sa == -half && sb == -1) begin
        q = -half;
        r = 0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
      v = dq ? q : (dr ? r : 0);
      res = res | ((v & mask) << (l * w));
    end
    return res[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every cycle out of reset: ready only when an op is outstanding, at the right
  // cycle with the right value; result zero otherwise.
  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      if (ready) begin
        chk("ready_expected", {31'b0, pending}, 32'd1);
        if (pending) begin
          chk("result", result, exp_res);
          chk("latency", cyc - start_cyc, exp_lat);
          pending = 1'b0;
        end
      end else begin
        chk("result_idle_zero", result, 32'd0);
      end
    end
  end

  // Waits for ready; after acceptance the operand inputs are scrambled to show they are ignored.
  task automatic wait_ready();
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clock);
      n++;
      if (ready) got = 1'b1;
      else if (n >= 2) begin
        crs1  = $urandom;
        crs2  = $urandom;
        pw    = 5'($urandom);
        div_q = 1'($urandom);
        div_r = 1'($urandom);
        div_s = 1'($urandom);
      end
    end
    chk("ready_seen", {31'b0, got}, 32'd1);
    if (!got) pending = 1'b0;
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] p,
                    input logic dq, input logic dr, input logic sg, input logic [31:0] e);
    @(posedge clock);
    #1;
    crs1 = a; crs2 = b; pw = p; div_q = dq; div_r = dr; div_s = sg; valid = 1'b1;
    exp_res   = e;
    exp_lat   = lane_w(p) + 1;
    start_cyc = cyc;
    pending   = 1'b1;
    wait_ready();
  endtask

  task automatic pin(input logic [31:0] a, input logic [31:0] b, input logic [4:0] p,
                     input logic dq, input logic dr, input logic sg, input logic [31:0] lit);
    chk("model_pin", model(a, b, p, dq, dr, sg), lit);
    op(a, b, p, dq, dr, sg, lit);
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
    valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; valid = 1'b0; div_q = 1'b0; div_r = 1'b0; div_s = 1'b0;
    pw = '0; crs1 = '0; crs2 = '0;
    #12;
    chk("reset_ready", {31'b0, ready}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(posedge clock);
    #1 resetn = 1'b1;

    pin(32'd100, 32'd7, 5'b00001, 1'b1, 1'b0, 1'b0, 32'd14);
    idle();
    pin(32'd100, 32'd7, 5'b00001, 1'b0, 1'b1, 1'b0, 32'd2);
    pin(32'hFF640A09, 32'h10070300, 5'b00100, 1'b1, 1'b0, 1'b0, 32'h0F0E03FF);
    pin(32'hFF640A09, 32'h10070300, 5'b00100, 1'b0, 1'b1, 1'b0, 32'h0F020109);
    pin(32'hFFFFFFFF, 32'h55555555, 5'b10000, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF);
    pin(32'hFFFFFFFF, 32'h55555555, 5'b10000, 1'b0, 1'b1, 1'b0, 32'h00000000);
    pin(32'h00001234, 32'h00000005, 5'b00011, 1'b1, 1'b0, 1'b0, 32'h00000000);
    pin(32'hDEADBEEF, 32'h00000000, 5'b00001, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF);

    // Abort by dropping valid in cycle 5, then an immediate new op.
    @(posedge clock);
    #1;
    crs1 = 32'd1000; crs2 = 32'd3; pw = 5'b00001; div_q = 1'b1; div_r = 1'b0; div_s = 1'b0;
    valid = 1'b1;
    pending = 1'b0;
    repeat (5) @(posedge clock);
    #1 valid = 1'b0;
    @(negedge clock);
    chk("abort_ready", {31'b0, ready}, 32'd0);
    pin(32'd50, 32'd5, 5'b00001, 1'b1, 1'b0, 1'b0, 32'd10);

    // Reset in cycle 10 of a pw=16 op; valid stays high with new operands across the release.
    @(posedge clock);
    #1;
    crs1 = 32'h12345678; crs2 = 32'h00030007; pw = 5'b00010; div_q = 1'b1; div_r = 1'b0;
    div_s = 1'b0; valid = 1'b1;
    pending = 1'b0;
    repeat (10) @(posedge clock);
    #3 resetn = 1'b0;
    #1;
    chk("reset_mid_ready", {31'b0, ready}, 32'd0);
    chk("reset_mid_result", result, 32'd0);
    crs1 = 32'h00640064; crs2 = 32'h000A0005;
    chk("model_pin", model(crs1, crs2, 5'b00010, 1'b1, 1'b0, 1'b0), 32'h000A0014);
    @(posedge clock);
    #1 resetn = 1'b1;
    exp_res   = 32'h000A0014;
    exp_lat   = 17;
    start_cyc = cyc;
    pending   = 1'b1;
    wait_ready();

`ifdef P_DIV_SIGNED_EN
    pin(32'h8000FFF9, 32'hFFFF0002, 5'b00010, 1'b1, 1'b0, 1'b1, 32'h8000FFFD);
    pin(32'h8000FFF9, 32'hFFFF0002, 5'b00010, 1'b0, 1'b1, 1'b1, 32'h0000FFFF);
    pin(32'h000000F9, 32'h00000000, 5'b00100, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF);
    pin(32'h000000F9, 32'h00000000, 5'b00100, 1'b0, 1'b1, 1'b1, 32'h000000F9);
    pin(32'h80808080, 32'hFFFFFFFF, 5'b00100, 1'b1, 1'b0, 1'b1, 32'h80808080);
`endif

    for (int i = 0; i < 150; i++) begin
      logic [4:0]  p;
      logic [31:0] a, b;
      logic        dq, dr, sg;
      case ($urandom_range(0, 5))
        0: p = 5'b00001;
        1: p = 5'b00010;
        2: p = 5'b00100;
        3: p = 5'b01000;
        4: p = 5'b10000;
        default: p = 5'($urandom);
      endcase
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = b >> $urandom_range(0, 31);
        1: b = b & 32'h00FF00F0;
        default: ;
      endcase
      dq = 1'($urandom_range(0, 1));
      dr = dq ? 1'($urandom_range(0, 1)) : 1'b1;
`ifdef P_DIV_SIGNED_EN
      sg = 1'($urandom_range(0, 1));
`else
      sg = 1'b0;
`endif
      op(a, b, p, dq, dr, sg, model(a, b, p, dq, dr, sg));
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    repeat (3) @(posedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
